// File: rtl/ddr_line_read_sched_pkg.sv
// Shared types and constants for the display-path DDR line read scheduler.
package ddr_rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    ABORT = 2'd3
  } sched_state_t;

  // Lines the scheduler may have requested ahead of the line being displayed.
  localparam int MAX_OUTSTANDING = 2;

endpackage

// File: rtl/ddr_line_read_sched_if.sv
// DDR line request handshake plus prefetch FIFO read port, seen from the scheduler.
interface ddr_line_read_sched_if #(
  parameter int DATA_W = 32,
  parameter int LINE_W = 12
);
  logic              line_req;
  logic [LINE_W-1:0] line_req_addr;
  logic              line_ack;
  logic              fifo_rd_en;
  logic              fifo_rd_vld;
  logic [DATA_W-1:0] fifo_rd_data;

  modport master (
    output line_req, line_req_addr, fifo_rd_en,
    input  line_ack, fifo_rd_vld, fifo_rd_data
  );

  modport slave (
    input  line_req, line_req_addr, fifo_rd_en,
    output line_ack, fifo_rd_vld, fifo_rd_data
  );
endinterface

// File: rtl/ddr_line_read_sched_line_req_ctrl.sv
// Line request handshake: holds req/addr until ack and limits lines in flight ahead of display.
module line_req_ctrl
  import ddr_rd_sched_pkg::*;
#(
  parameter int V_ACTIVE = 720,
  parameter int LINE_W   = 12
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              i_trig_en,
  input  logic              i_clr,
  input  logic [LINE_W-1:0] i_line_cnt,
  input  logic              i_ack,
  output logic              o_req,
  output logic [LINE_W-1:0] o_req_addr
);
  localparam logic [LINE_W-1:0] C_V_ACTIVE = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W:0]   C_MAX_OUT  = (LINE_W+1)'(MAX_OUTSTANDING);

  logic              r_req;
  logic [LINE_W-1:0] r_req_addr;
  logic [LINE_W-1:0] r_req_cnt;
  logic              w_room;
  logic              w_trig;

  // Written as req < line + max so a display running ahead of data never wraps the check.
  assign w_room = {1'b0, r_req_cnt} < ({1'b0, i_line_cnt} + C_MAX_OUT);
  assign w_trig = i_trig_en & ~r_req & (r_req_cnt < C_V_ACTIVE) & w_room;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_req      <= 1'b0;
      r_req_addr <= '0;
      r_req_cnt  <= '0;
    end else begin
      if (r_req && i_ack) begin
        r_req     <= 1'b0;
        r_req_cnt <= r_req_cnt + 1'b1;
      end else if (w_trig) begin
        r_req      <= 1'b1;
        r_req_addr <= r_req_cnt;
      end
      if (i_clr) r_req_cnt <= '0;
    end
  end

  assign o_req      = r_req;
  assign o_req_addr = r_req_addr;
endmodule

// File: rtl/ddr_line_read_sched.sv
// Pixel-domain read scheduler: paces DDR line requests, pops the prefetch FIFO under de_in.
//   IDLE  | waiting for frame start
//   PRIME | clearing line/request counters
//   RUN   | requesting lines and displaying pixels
//   ABORT | frame cut short, waiting for the in-flight request's ack
module ddr_line_read_sched
  import ddr_rd_sched_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int DATA_W   = 32,
  parameter int LINE_W   = 12,
  parameter int PIX_W    = 12
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 i_vs_in,
  input  logic                 i_de_in,
  ddr_line_read_sched_if.master bus,
  output logic                 o_pix_de,
  output logic [DATA_W-1:0]    o_pix_data,
  output logic                 o_underflow,
  output logic                 o_frame_abort,
  output logic                 o_frame_done
);
  localparam logic [LINE_W-1:0] C_LAST_LINE = LINE_W'(V_ACTIVE - 1);
  localparam logic [PIX_W-1:0]  C_H_ACTIVE  = PIX_W'(H_ACTIVE);

  sched_state_t      r_state, w_state_nxt;
  logic              r_de_d;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [LINE_W-1:0] r_line_cnt;
  logic              r_pix_de;
  logic [DATA_W-1:0] r_pix_data;
  logic              r_underflow, r_frame_abort, r_frame_done;
  logic              w_run, w_clr, w_fall, w_done, w_abort, w_uf_set, w_trig_en;
  logic              w_req;
  logic [LINE_W-1:0] w_req_addr;

  assign w_run   = (r_state == RUN);
  assign w_clr   = (r_state == PRIME);
  assign w_fall  = r_de_d & ~i_de_in;
  assign w_done  = w_run & w_fall & (r_line_cnt == C_LAST_LINE);
  // line_cnt is always below V_ACTIVE while in RUN, so any vs_in there aborts.
  assign w_abort = w_run & i_vs_in & ~w_done;
  assign w_uf_set = w_run & ((i_de_in & ~bus.fifo_rd_vld) |
                             (w_fall & (r_pix_cnt != C_H_ACTIVE)));
  assign w_trig_en = w_run & (w_state_nxt == RUN);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (i_vs_in) w_state_nxt = PRIME;
      PRIME: w_state_nxt = RUN;
      RUN: begin
        if (w_done)       w_state_nxt = IDLE;
        else if (w_abort) w_state_nxt = (w_req && !bus.line_ack) ? ABORT : PRIME;
      end
      ABORT: if (bus.line_ack) w_state_nxt = PRIME;
      default: w_state_nxt = IDLE;
    endcase
  end

  line_req_ctrl #(
    .V_ACTIVE(V_ACTIVE),
    .LINE_W  (LINE_W)
  ) u_line_req_ctrl (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .i_trig_en (w_trig_en),
    .i_clr     (w_clr),
    .i_line_cnt(r_line_cnt),
    .i_ack     (bus.line_ack),
    .o_req     (w_req),
    .o_req_addr(w_req_addr)
  );

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_de_d        <= 1'b0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_pix_de      <= 1'b0;
      r_pix_data    <= '0;
      r_underflow   <= 1'b0;
      r_frame_abort <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_de_d        <= i_de_in;
      r_pix_de      <= i_de_in;
      r_pix_data    <= (i_de_in && bus.fifo_rd_vld) ? bus.fifo_rd_data : '0;
      r_underflow   <= w_uf_set | (r_underflow & ~i_vs_in);
      r_frame_abort <= w_abort;
      r_frame_done  <= w_done;
      if (w_clr) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
      end else if (w_run) begin
        if (w_fall) begin
          r_pix_cnt  <= '0;
          r_line_cnt <= r_line_cnt + 1'b1;
        end else if (i_de_in) begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.line_req      = w_req;
  assign bus.line_req_addr = w_req_addr;
  assign bus.fifo_rd_en    = w_run & i_de_in & bus.fifo_rd_vld;
  assign o_pix_de          = r_pix_de;
  assign o_pix_data        = r_pix_data;
  assign o_underflow       = r_underflow;
  assign o_frame_abort     = r_frame_abort;
  assign o_frame_done      = r_frame_done;
endmodule
